// File: rtl/capiano_pkg.sv
// Shared constants, colour types and palette for the on-screen piano key renderer.
package capiano_pkg;

    localparam int NUM_KEYS    = 8;
    localparam int KEY_W       = 80;
    localparam int KEY_TOP     = 240;
    localparam int HOLD_FRAMES = 15;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb_t;

    localparam rgb_t COL_BLACK = '{r: 3'd0, g: 3'd0, b: 3'd0};
    localparam rgb_t COL_WHITE = '{r: 3'd7, g: 3'd7, b: 3'd7};
    localparam rgb_t COL_BG    = '{r: 3'd0, g: 3'd0, b: 3'd2};

    localparam rgb_t PAL [8] = '{
        '{r: 3'd7, g: 3'd0, b: 3'd0},
        '{r: 3'd7, g: 3'd3, b: 3'd0},
        '{r: 3'd7, g: 3'd7, b: 3'd0},
        '{r: 3'd0, g: 3'd7, b: 3'd0},
        '{r: 3'd0, g: 3'd7, b: 3'd7},
        '{r: 3'd0, g: 3'd0, b: 3'd7},
        '{r: 3'd5, g: 3'd0, b: 3'd7},
        '{r: 3'd7, g: 3'd0, b: 3'd5}
    };

    // Pixel classification carried from the geometry stage to the colour stage.
    typedef enum logic [1:0] {
        REG_NONE    = 2'd0,
        REG_BG      = 2'd1,
        REG_KEY_OFF = 2'd2,
        REG_KEY_ON  = 2'd3
    } region_t;

    function automatic rgb_t key_colour(input region_t region, input logic border,
                                        input logic [2:0] pal_idx);
        rgb_t c;
        c = COL_BLACK;
        case (region)
            REG_BG:      c = COL_BG;
            REG_KEY_OFF: c = border ? COL_BLACK : COL_WHITE;
            REG_KEY_ON:  c = border ? COL_BLACK : PAL[pal_idx];
            default:     c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/key_sustain.sv
// Per-key release sustain: holds a key lit for 2*HOLD_FRAMES frames after release.
module key_sustain #(
    parameter int HOLD_FRAMES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic snap_old,
    input  logic snap_new,
    output logic lit
);
    import capiano_pkg::*;

    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic       phase_r;
    logic       phase_s;

    // Next sustain state; phase restarts on every load so a release always yields the full hold.
    always_comb begin
        cnt_s   = cnt_r;
        phase_s = phase_r;
        if (frame_start) begin
            if (snap_new) begin
                cnt_s   = 4'd0;
                phase_s = 1'b0;
            end else if (snap_old) begin
                cnt_s   = 4'(HOLD_FRAMES);
                phase_s = 1'b0;
            end else if (cnt_r != 4'd0) begin
                cnt_s   = phase_r ? (cnt_r - 4'd1) : cnt_r;
                phase_s = ~phase_r;
            end else begin
                phase_s = 1'b0;
            end
        end else begin
            cnt_s   = cnt_r;
        end
    end

    // Sustain counter and half-rate phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 4'd0;
            phase_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            phase_r <= phase_s;
        end
    end

    assign lit = snap_old | (cnt_r != 4'd0);

endmodule

// File: rtl/key_renderer.sv
// Renders a row of piano keys into a 2-cycle VGA pixel pipeline.
// Optional release sustain is built when CAPIANO_SUSTAIN_EN is defined.
module key_renderer #(
    parameter int NUM_KEYS    = capiano_pkg::NUM_KEYS,
    parameter int KEY_W       = capiano_pkg::KEY_W,
    parameter int KEY_TOP     = capiano_pkg::KEY_TOP,
    parameter int HOLD_FRAMES = capiano_pkg::HOLD_FRAMES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    input  logic                pix_valid,
    input  logic                frame_start,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [2:0]          r,
    output logic [2:0]          g,
    output logic [2:0]          b,
    output logic                out_valid
);
    import capiano_pkg::*;

    localparam int          IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [10:0] KEYS_END = 11'(NUM_KEYS * KEY_W);
    localparam logic [9:0]  TOP_ROW  = 10'(KEY_TOP);
    localparam logic [9:0]  LAST_COL = 10'(KEY_W - 1);

    logic [NUM_KEYS-1:0] sync1_r;
    logic [NUM_KEYS-1:0] sync2_r;
    logic [NUM_KEYS-1:0] snap_r;
    logic [NUM_KEYS-1:0] lit_s;

    logic [IDX_W-1:0]    idx_s;
    logic [9:0]          off_s;
    region_t             region_s;

    logic                valid1_r;
    logic [IDX_W-1:0]    idx1_r;
    logic [9:0]          off1_r;
    region_t             region1_r;

    logic                border_s;
    logic [2:0]          pal_idx_s;
    rgb_t                colour_s;

    // Key synchroniser and per-frame snapshot; the snapshot only moves on frame_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
            snap_r  <= '0;
        end else begin
            sync1_r <= keys;
            sync2_r <= sync1_r;
            snap_r  <= frame_start ? sync2_r : snap_r;
        end
    end

`ifdef CAPIANO_SUSTAIN_EN
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_sustain
        key_sustain #(
            .HOLD_FRAMES(HOLD_FRAMES)
        ) u_key_sustain (
            .clk        (clk),
            .rst_n      (rst),
            .frame_start(frame_start),
            .snap_old   (snap_r[k]),
            .snap_new   (sync2_r[k]),
            .lit        (lit_s[k])
        );
    end
`else
    assign lit_s = snap_r;
`endif

    // Geometry: comparator chain picks the last key base not above pix_x.
    always_comb begin
        idx_s    = '0;
        off_s    = pix_x;
        region_s = REG_NONE;
        for (int i = 1; i < NUM_KEYS; i++) begin
            idx_s = ({1'b0, pix_x} >= 11'(i * KEY_W)) ? IDX_W'(i) : idx_s;
            off_s = ({1'b0, pix_x} >= 11'(i * KEY_W)) ? (pix_x - 10'(i * KEY_W)) : off_s;
        end
        // Lit state is resolved here so a pixel sharing a cycle with frame_start sees the old snapshot.
        if ({1'b0, pix_x} >= KEYS_END) begin
            region_s = REG_NONE;
        end else if (pix_y < TOP_ROW) begin
            region_s = REG_BG;
        end else if (lit_s[idx_s]) begin
            region_s = REG_KEY_ON;
        end else begin
            region_s = REG_KEY_OFF;
        end
    end

    // Stage 1 pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid1_r  <= 1'b0;
            idx1_r    <= '0;
            off1_r    <= 10'd0;
            region1_r <= REG_NONE;
        end else begin
            valid1_r  <= pix_valid;
            idx1_r    <= idx_s;
            off1_r    <= off_s;
            region1_r <= region_s;
        end
    end

    // Colour selection from the registered classification.
    always_comb begin
        border_s  = (off1_r == 10'd0) || (off1_r == LAST_COL);
        pal_idx_s = 3'(idx1_r);
        colour_s  = valid1_r ? key_colour(region1_r, border_s, pal_idx_s) : COL_BLACK;
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r         <= 3'd0;
            g         <= 3'd0;
            b         <= 3'd0;
            out_valid <= 1'b0;
        end else begin
            r         <= colour_s.r;
            g         <= colour_s.g;
            b         <= colour_s.b;
            out_valid <= valid1_r;
        end
    end

endmodule
